mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Shares one combinational 16x16 signed Booth-2/Wallace multiplier (mult_16_16_top) among
//  N_REQ requesters. Round-robin arbitration, valid/ready handshakes on both sides, and a
//  2-stage register pipeline around the multiplier (operand stage S1, result stage S2).
//  Each result is returned with the requester index. A 16-bit completed-op counter is kept.
// PARAMETERS
//  N_REQ  4  number of requesters, 2..8
//  ID_W   2  width of res_id; must equal max(1, clog2(N_REQ))
// PORTS
//  clk        in   1         single clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   N_REQ     request valid, one bit per requester
//  req_ready  out  N_REQ     request accepted this cycle (one-hot or zero)
//  req_a      in   16*N_REQ  signed multiplicand, requester i at [16*i+:16]
//  req_b      in   16*N_REQ  signed multiplier, requester i at [16*i+:16]
//  res_valid  out  1         result valid
//  res_ready  in   1         downstream accepts result
//  res_data   out  32        signed product a*b (two's complement, full 32 bits)
//  res_id     out  ID_W      index of the requester that issued the operation
//  op_count   out  16        number of results handed off (res_valid & res_ready), wraps
// BEHAVIOUR
//  Reset: s1_valid=0, res_valid=0, res_data=0, res_id=0, op_count=0, rr_ptr=N_REQ-1
//   (so requester 0 has highest priority first). req_ready=0 while rst=1.
//  Pipeline control (combinational):
//   advance = !res_valid | res_ready;  s1_free = !s1_valid | advance.
//  Arbitration: search req_valid starting at (rr_ptr+1) mod N_REQ upward with wrap;
//   first set bit is the grant g. req_ready[g] = s1_free & req_valid[g]; others 0.
//   req_ready may depend combinationally on req_valid; requesters must not make req_valid
//   depend on req_ready. Handshake = req_valid[i] & req_ready[i].
//  On handshake: S1 <= {req_a[g], req_b[g], id=g}, s1_valid<=1, rr_ptr<=g.
//   rr_ptr changes only on a handshake. If s1_free & no request: s1_valid<=0 when advance.
//  S1 operands drive the multiplier; on advance & s1_valid: res_data<=product,
//   res_id<=S1 id, res_valid<=1. On advance & !s1_valid: res_valid<=0 (data held).
//  Latency: handshake in cycle T -> res_valid=1 in cycle T+2 with no stall.
//  Throughput: one op per cycle sustained while res_ready=1.
//  Backpressure: res_valid & !res_ready -> res_data/res_id/res_valid hold; S1 holds;
//   if s1_valid, req_ready all 0; if S1 empty, one more op may enter S1 (2 ops max in flight).
//  Results leave in acceptance order; none dropped, none duplicated.
//  op_count += 1 on each res_valid & res_ready; 0xFFFF wraps to 0x0000.
//  Reset mid-operation: in-flight S1/S2 contents discarded, no result emitted, rr_ptr reset.
//  Inputs req_a/req_b need only be stable in the handshake cycle.
// TESTING
//  1 single op: req0 a=3,b=-5, res_ready=1 -> res_valid at T+2, res_data=0xFFFFFFF1, id=0
//  2 all 4 valid every cycle, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, ids match
//  3 corner products: -32768*-32768 -> 0x40000000; -32768*32767 -> 0xC0008000; 0*x -> 0
//  4 hold res_ready=0 5 cycles with 2 ops in flight -> res_* stable, req_ready=0,
//    release -> both results in order, no loss; op_count +2
//  5 rst=1 for one cycle with S1,S2 valid -> res_valid=0 next cycle, no stale result,
//    next grant goes to requester 0
//  6 65537 completed ops -> op_count=0x0001 (wrap); random a,b vs reference model a*b

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: one shared signed 16x16 multiplier serving N_REQ requesters.
//
// Requests are picked round-robin, registered into an operand stage (S1), multiplied
// combinationally, and the product is registered into the result stage (S2), which
// drives the res_* outputs. A handshake in cycle T shows up on res_valid in cycle T+2.
// The pipeline sustains one op per cycle while res_ready stays high.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and ready
// are both high. valid does not depend on ready. req_ready may depend combinationally
// on req_valid. Once res_valid is high, res_data/res_id hold until res_ready is seen.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [N_REQ]     per-requester request valid
//   req_ready  [N_REQ]     per-requester accept, one-hot or zero
//   req_a      [16*N_REQ]  signed multiplicands, requester i at [16*i +: 16]
//   req_b      [16*N_REQ]  signed multipliers,  requester i at [16*i +: 16]
//   res_valid  result valid
//   res_ready  downstream accepts result
//   res_data   [32]        signed product
//   res_id     [ID_W]      index of the issuing requester
//   op_count   [16]        results handed off, wraps at 16 bits

module mult_16_16_top (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    // Radix-4 Booth recoding of b gives 8 partial products of a. A carry-save tree
    // reduces them to two rows, and one carry-propagate add produces the product.
    // All arithmetic is modulo 2^32, which is exact for a 16x16 signed product.
    logic [31:0] pp [8];
    logic [31:0] a_pos;
    logic [31:0] a_neg;
    logic [16:0] b_pad;

    function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        logic [31:0] s;
        logic [31:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    always_comb begin
        a_pos = {{16{a[15]}}, a};
        a_neg = ~a_pos + 32'd1;
        // Implicit zero to the right of b's LSB for the first Booth window.
        b_pad = {b, 1'b0};
        for (int i = 0; i < 8; i++) begin
            case (b_pad[2*i +: 3])
                3'b001, 3'b010: pp[i] = a_pos << (2*i);
                3'b011:         pp[i] = a_pos << (2*i + 1);
                3'b100:         pp[i] = a_neg << (2*i + 1);
                3'b101, 3'b110: pp[i] = a_neg << (2*i);
                default:        pp[i] = 32'd0;
            endcase
        end
    end

    logic [63:0] l1_0, l1_1, l2_0, l2_1, l3_0, l4_0;

    always_comb begin
        // 8 rows -> 6 -> 4 -> 3 -> 2
        l1_0 = csa(pp[0], pp[1], pp[2]);
        l1_1 = csa(pp[3], pp[4], pp[5]);
        l2_0 = csa(l1_0[31:0], l1_0[63:32], l1_1[31:0]);
        l2_1 = csa(l1_1[63:32], pp[6], pp[7]);
        l3_0 = csa(l2_0[31:0], l2_0[63:32], l2_1[31:0]);
        l4_0 = csa(l3_0[31:0], l3_0[63:32], l2_1[63:32]);
        p    = l4_0[31:0] + l4_0[63:32];
    end
endmodule

module mult_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [15:0]           op_count
);
    logic [ID_W-1:0] rr_ptr;
    logic            s1_valid;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic [ID_W-1:0] s1_id;

    logic            advance;
    logic            s1_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            take;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic [31:0]     product;

    // S2 moves whenever it is empty or being drained; S1 can load when it is empty
    // or its contents move into S2 on this edge.
    assign advance = !res_valid || res_ready;
    assign s1_free = !s1_valid || advance;

    // Round-robin pick: lowest valid index above rr_ptr, otherwise lowest valid index
    // overall (the wrap-around). Scanning downward lets the lowest index win.
    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            lo_found;
    logic [ID_W-1:0] lo_id;

    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (ID_W'(i) > rr_ptr) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        grant_found = hi_found || lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
    end

    assign take = !rst && s1_free && grant_found;

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready = N_REQ'(1) << grant_id;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    mult_16_16_top u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            op_count  <= '0;
            rr_ptr    <= ID_W'(N_REQ - 1);
        end else begin
            if (take) begin
                s1_valid <= 1'b1;
                s1_a     <= sel_a;
                s1_b     <= sel_b;
                s1_id    <= grant_id;
                rr_ptr   <= grant_id;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                res_valid <= s1_valid;
                // Data is only refreshed by a real op so a bubble leaves it unchanged.
                if (s1_valid) begin
                    res_data <= product;
                    res_id   <= s1_id;
                end
            end

            if (res_valid && res_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
module tb_mult_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int EW    = ID_W + 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [16*N_REQ-1:0]  req_a = '0;
    logic [16*N_REQ-1:0]  req_b = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [31:0]          res_data;
    logic [ID_W-1:0]      res_id;
    logic [15:0]          op_count;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {id, product} pushed on each modelled request handshake.
    logic [EW-1:0] exp_q[$];

    // Reference model of arbitration pointer, pipeline occupancy and counter.
    int          m_ptr   = N_REQ - 1;
    bit          m_s1v   = 1'b0;
    bit          m_resv  = 1'b0;
    logic [15:0] m_count = '0;

    mult_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        return sa * sb;
    endfunction

    // ---------------- scoreboard / monitor (samples on negedge) ----------------
    always @(negedge clk) begin
        int          g;
        bit          found;
        bit          adv;
        bit          free;
        bit          nxt_s1v;
        logic [N_REQ-1:0] exp_ready;
        logic [EW-1:0]    exp;
        if (rst) begin
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL ready_in_reset: got %b expected 0", req_ready);
            end
            exp_q.delete();
            m_ptr   = N_REQ - 1;
            m_s1v   = 1'b0;
            m_resv  = 1'b0;
            m_count = '0;
        end else begin
            checks++;
            if (res_valid !== m_resv) begin
                failures++;
                $display("FAIL res_valid_model: got %b expected %b", res_valid, m_resv);
            end
            checks++;
            if (op_count !== m_count) begin
                failures++;
                $display("FAIL op_count_model: got %h expected %h", op_count, m_count);
            end
            adv   = !m_resv || res_ready;
            free  = !m_s1v || adv;
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= N_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            exp_ready = (free && found) ? (N_REQ'(1) << g) : '0;
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL req_ready_model: got %b expected %b", req_ready, exp_ready);
            end

            if (m_resv && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got id=%0d data=%h expected none",
                             res_id, res_data);
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if ({res_id, res_data} !== exp) begin
                        failures++;
                        $display("FAIL result: got id=%0d data=%h expected id=%0d data=%h",
                                 res_id, res_data, exp[EW-1:32], exp[31:0]);
                    end
                end
                m_count = m_count + 16'd1;
            end

            nxt_s1v = m_s1v;
            if (free && found) begin
                exp_q.push_back({ID_W'(g), ref_mul(req_a[16*g +: 16], req_b[16*g +: 16])});
                m_ptr   = g;
                nxt_s1v = 1'b1;
            end else if (adv) begin
                nxt_s1v = 1'b0;
            end
            if (adv) m_resv = m_s1v;
            m_s1v = nxt_s1v;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && res_valid == 1'b0) break;
            step();
        end
        checks++;
        if (exp_q.size() != 0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout: got pending=%0d res_valid=%b expected 0/0",
                     exp_q.size(), res_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'd0 || res_id !== '0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%h expected 0/0/0/0",
                     res_valid, res_data, res_id, op_count);
        end
        step();
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single_op();
        res_ready = 1'b1;
        req_a[15:0] = 16'd3;
        req_b[15:0] = -16'sd5;
        req_valid   = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_t1: got %b expected 0", res_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFF1 || res_id !== 2'd0) begin
            failures++;
            $display("FAIL single_result: got v=%b d=%h id=%0d expected 1/fffffff1/0",
                     res_valid, res_data, res_id);
        end
        step();
        drain();
    endtask

    task automatic test_round_robin();
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_operands();
            req_valid = '1;
            @(negedge clk);
            checks++;
            if (req_ready !== (4'b0001 << (i % N_REQ))) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready,
                         4'b0001 << (i % N_REQ));
            end
            if (i >= 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== ID_W'((i - 2) % N_REQ)) begin
                    failures++;
                    $display("FAIL rr_res_id[%0d]: got v=%b id=%0d expected 1/%0d",
                             i, res_valid, res_id, (i - 2) % N_REQ);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_corner_products();
        logic [15:0] ca [3];
        logic [15:0] cb [3];
        logic [31:0] cp [3];
        ca[0] = 16'h8000; cb[0] = 16'h8000; cp[0] = 32'h4000_0000;
        ca[1] = 16'h8000; cb[1] = 16'h7FFF; cp[1] = 32'hC000_8000;
        ca[2] = 16'h0000; cb[2] = 16'd12345; cp[2] = 32'h0000_0000;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_a[16*(k+1) +: 16] = ca[k];
            req_b[16*(k+1) +: 16] = cb[k];
            req_valid = 4'b0001 << (k + 1);
            step();
            req_valid = '0;
            step();
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== cp[k] || res_id !== ID_W'(k + 1)) begin
                failures++;
                $display("FAIL corner[%0d]: got v=%b d=%h id=%0d expected 1/%h/%0d",
                         k, res_valid, res_data, res_id, cp[k], k + 1);
            end
            step();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt0;
        logic [31:0] px;
        logic [31:0] py;
        px = ref_mul(16'd1234, -16'sd77);
        py = ref_mul(-16'sd300, 16'd555);
        cnt0 = m_count;
        res_ready = 1'b0;
        req_a[31:16] = 16'd1234;  req_b[31:16] = -16'sd77;
        req_a[47:32] = -16'sd300; req_b[47:32] = 16'd555;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_second_accept: got %b expected 0100", req_ready);
        end
        step();
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || res_valid !== 1'b1 || res_data !== px || res_id !== 2'd1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h id=%0d expected 0000/1/%h/1",
                         i, req_ready, res_valid, res_data, res_id, px);
            end
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== px || res_id !== 2'd1) begin
            failures++;
            $display("FAIL bp_release_first: got v=%b d=%h id=%0d expected 1/%h/1",
                     res_valid, res_data, res_id, px);
        end
        step();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== py || res_id !== 2'd2) begin
            failures++;
            $display("FAIL bp_release_second: got v=%b d=%h id=%0d expected 1/%h/2",
                     res_valid, res_data, res_id, py);
        end
        step();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || op_count !== cnt0 + 16'd2) begin
            failures++;
            $display("FAIL bp_count: got v=%b cnt=%h expected 0/%h", res_valid, op_count,
                     cnt0 + 16'd2);
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p0;
        p0 = ref_mul(16'd7, 16'd9);
        res_ready = 1'b0;
        req_a[31:16] = 16'd100; req_b[31:16] = 16'd200;
        req_a[47:32] = 16'd300; req_b[47:32] = 16'd400;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup: got %b expected 1", res_valid);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        req_a[15:0] = 16'd7;
        req_b[15:0] = 16'd9;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_after: got v=%b rdy=%b expected 0/0001", res_valid, req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_stale: got %b expected 0", res_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== p0) begin
            failures++;
            $display("FAIL midrst_first_result: got v=%b id=%0d d=%h expected 1/0/%h",
                     res_valid, res_id, res_data, p0);
        end
        step();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_operands();
            req_valid = N_REQ'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
    endtask

    task automatic test_count_wrap();
        int issued;
        int cyc;
        apply_reset();
        res_ready = 1'b1;
        req_valid = '1;
        issued = 0;
        cyc    = 0;
        while (issued < 65537 && cyc < 70000) begin
            rand_operands();
            @(negedge clk);
            if (req_ready != '0) issued++;
            cyc++;
            step();
        end
        checks++;
        if (issued != 65537) begin
            failures++;
            $display("FAIL wrap_issue_budget: got %0d expected 65537", issued);
        end
        drain();
        @(negedge clk);
        checks++;
        if (op_count !== 16'h0001) begin
            failures++;
            $display("FAIL op_count_wrap: got %h expected 0001", op_count);
        end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_corner_products();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
